// File: rtl/mealy_machine.sv
// Serial bit-pattern detector: a Mealy FSM whose state is the length of the matched pattern prefix.
// Transitions are derived from PATTERN at elaboration (KMP failure function), so any pattern works.
module mealy_machine #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y
);

  localparam int SW = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;

  typedef logic [SW-1:0] state_t;

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input int i);
    return PATTERN[PAT_LEN-1-i];
  endfunction

  // Longest pattern prefix that is a suffix of (prefix_k followed by b).
  // A result of PAT_LEN means the full pattern has just been seen.
  function automatic int kmp_next(input int k, input logic b);
    int   best;
    int   pos;
    logic ok;
    logic sb;
    best = 0;
    for (int j = 1; j <= PAT_LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          pos = k + 1 - j + i;
          sb  = (pos == k) ? b : pat_bit(pos);
          if (pat_bit(i) != sb) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int border();
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j < PAT_LEN; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (pat_bit(i) != pat_bit(PAT_LEN - j + i)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  localparam int BORDER = border();

  logic [PAT_LEN-1:0][SW-1:0] nxt0;
  logic [PAT_LEN-1:0][SW-1:0] nxt1;
  logic [PAT_LEN-1:0]         hit0;
  logic [PAT_LEN-1:0]         hit1;

  for (genvar k = 0; k < PAT_LEN; k++) begin : g_trans
    localparam int J0  = kmp_next(k, 1'b0);
    localparam int J1  = kmp_next(k, 1'b1);
    localparam int J0S = (J0 == PAT_LEN) ? (OVERLAP ? BORDER : 0) : J0;
    localparam int J1S = (J1 == PAT_LEN) ? (OVERLAP ? BORDER : 0) : J1;
    assign nxt0[k] = SW'(J0S);
    assign nxt1[k] = SW'(J1S);
    assign hit0[k] = (J0 == PAT_LEN);
    assign hit1[k] = (J1 == PAT_LEN);
  end

  state_t state;
  state_t state_nxt;
  logic   y_raw;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= '0;
    else      state <= state_nxt;
  end

  // NOTE: defaults are assigned first so no path through this block can infer a latch.
  always_comb begin
    state_nxt = state;
    y_raw     = 1'b0;
    if (x) begin
      state_nxt = nxt1[state];
      y_raw     = hit1[state];
    end else begin
      state_nxt = nxt0[state];
      y_raw     = hit0[state];
    end
  end

  // The flag is gated so it drops as soon as reset asserts, even before the state clears.
  assign y = y_raw & rst;

endmodule

// File: tb/tb_mealy_machine.sv
// Directed self-checking bench for mealy_machine: default pattern with and without overlap,
// failure transitions, asynchronous reset mid-pattern and a non-default 5-bit pattern.
module tb_mealy_machine;

  logic clk;
  logic rst;
  logic x;
  logic y_def;
  logic y_nov;
  logic y_p5;

  int n_cmp;
  int n_mis;

  mealy_machine #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u_def (
    .clk(clk), .rst(rst), .x(x), .y(y_def)
  );

  mealy_machine #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst(rst), .x(x), .y(y_nov)
  );

  mealy_machine #(.PAT_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1)) u_p5 (
    .clk(clk), .rst(rst), .x(x), .y(y_p5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one bit per cycle starting at a falling edge; observed flags are stored at the
  // same index as the bit that produced them (first bit at index n-1).
  task automatic run_stream(input logic [15:0] bits, input int n,
                            output logic [15:0] yd, output logic [15:0] yn,
                            output logic [15:0] yp);
    yd = '0;
    yn = '0;
    yp = '0;
    for (int i = 0; i < n; i++) begin
      x = bits[n-1-i];
      #1;
      yd[n-1-i] = y_def;
      yn[n-1-i] = y_nov;
      yp[n-1-i] = y_p5;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] yd, yn, yp;
    logic [15:0] exp_d;
    rst = 1'b0;
    x   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({y_def, y_nov, y_p5} !== 3'b000) begin
        n_mis++;
        $display("FAIL reset_hold cycle %0d: y(def,nov,p5)=%b expected 000", c, {y_def, y_nov, y_p5});
      end
    end
    @(negedge clk);
    rst   = 1'b1;
    exp_d = 16'b1011 & 16'h000f;
    exp_d = 16'b0001;
    run_stream(16'b1011, 4, yd, yn, yp);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (yd[3-i] !== exp_d[3-i]) begin
        n_mis++;
        $display("FAIL reset_first_match bit %0d: y=%b expected %b", i + 1, yd[3-i], exp_d[3-i]);
      end
    end
  endtask

  task automatic test_default_pattern();
    logic [15:0] yd, yn, yp;
    logic [15:0] exp_d;
    do_reset();
    // 1101 alone is not the pattern; the trailing 1 completes 1011.
    exp_d = 16'b00001;
    run_stream(16'b11011, 5, yd, yn, yp);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (yd[4-i] !== exp_d[4-i]) begin
        n_mis++;
        $display("FAIL default_stream bit %0d: y=%b expected %b", i + 1, yd[4-i], exp_d[4-i]);
      end
    end
  endtask

  task automatic test_overlap();
    logic [15:0] yd, yn, yp;
    logic [15:0] exp_d, exp_n;
    do_reset();
    exp_d = 16'b0001001;
    exp_n = 16'b0001000;
    run_stream(16'b1011011, 7, yd, yn, yp);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (yd[6-i] !== exp_d[6-i]) begin
        n_mis++;
        $display("FAIL overlap_on bit %0d: y=%b expected %b", i + 1, yd[6-i], exp_d[6-i]);
      end
      n_cmp++;
      if (yn[6-i] !== exp_n[6-i]) begin
        n_mis++;
        $display("FAIL overlap_off bit %0d: y=%b expected %b", i + 1, yn[6-i], exp_n[6-i]);
      end
    end
  endtask

  task automatic test_failure_transitions();
    logic [15:0] yd, yn, yp;
    logic [15:0] exp_d;
    do_reset();
    exp_d = 16'b0000001;
    run_stream(16'b1001011, 7, yd, yn, yp);
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (yd[6-i] !== exp_d[6-i]) begin
        n_mis++;
        $display("FAIL failure_stream bit %0d: y=%b expected %b", i + 1, yd[6-i], exp_d[6-i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] yd, yn, yp;
    logic [15:0] exp_d;
    do_reset();
    run_stream(16'b101, 3, yd, yn, yp);
    n_cmp++;
    if (yd[2:0] !== 3'b000) begin
      n_mis++;
      $display("FAIL async_prefix: y=%b expected 000", yd[2:0]);
    end
    // Both detectors now sit one bit from a match; a 1 on x completes it.
    x = 1'b1;
    #1;
    n_cmp++;
    if (y_def !== 1'b1) begin
      n_mis++;
      $display("FAIL async_pre_pulse: y=%b expected 1", y_def);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({y_def, y_nov} !== 2'b00) begin
      n_mis++;
      $display("FAIL async_during_pulse: y(def,nov)=%b expected 00", {y_def, y_nov});
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({y_def, y_nov} !== 2'b00) begin
      n_mis++;
      $display("FAIL async_after_pulse: y(def,nov)=%b expected 00", {y_def, y_nov});
    end
    @(negedge clk);
    // The 1 sampled after the pulse leaves S1 in both; 0,1,1 then completes 1011.
    exp_d = 16'b001;
    run_stream(16'b011, 3, yd, yn, yp);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (yd[2-i] !== exp_d[2-i]) begin
        n_mis++;
        $display("FAIL async_resume_def bit %0d: y=%b expected %b", i + 1, yd[2-i], exp_d[2-i]);
      end
      n_cmp++;
      if (yn[2-i] !== exp_d[2-i]) begin
        n_mis++;
        $display("FAIL async_resume_nov bit %0d: y=%b expected %b", i + 1, yn[2-i], exp_d[2-i]);
      end
    end
  endtask

  task automatic test_param5();
    logic [15:0] yd, yn, yp;
    logic [15:0] exp_p;
    do_reset();
    exp_p = 16'b00001001;
    run_stream(16'b11011011, 8, yd, yn, yp);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (yp[7-i] !== exp_p[7-i]) begin
        n_mis++;
        $display("FAIL param5_stream bit %0d: y=%b expected %b", i + 1, yp[7-i], exp_p[7-i]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst   = 1'b0;
    x     = 1'b0;
    test_reset();
    test_default_pattern();
    test_overlap();
    test_failure_transitions();
    test_async_reset();
    test_param5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
